easyaxi_rd_arb: RTL and testbench

Two-master AXI read-channel arbiter between two read masters and one read slave. It grants the shared AR channel round-robin and steers the R channel back to the granted master. One transaction is outstanding at a time: the AR grant is held until the R beat carrying `rlast` completes its handshake. It also checks each burst's beat count against `arlen` and pulses an error on mismatch.

---
 rtl/easyaxi_rd_arb.sv | 170 +++++++++++++++++
 tb/tb_easyaxi_rd_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_rd_arb.sv
// Two-master AXI read arbiter: round-robin AR grant, one transaction in flight,
// R channel steered back to the owner, with a beat-count check against arlen.
module easyaxi_rd_arb #(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned SIZE_W  = 3,
    parameter int unsigned BURST_W = 2,
    parameter int unsigned USER_W  = 1,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RESP_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    // master 0
    input  logic               m0_arvalid,
    output logic               m0_arready,
    input  logic [ID_W-1:0]    m0_arid,
    input  logic [ADDR_W-1:0]  m0_araddr,
    input  logic [LEN_W-1:0]   m0_arlen,
    input  logic [SIZE_W-1:0]  m0_arsize,
    input  logic [BURST_W-1:0] m0_arburst,
    input  logic [USER_W-1:0]  m0_aruser,
    output logic               m0_rvalid,
    input  logic               m0_rready,
    output logic [ID_W-1:0]    m0_rid,
    output logic [DATA_W-1:0]  m0_rdata,
    output logic [RESP_W-1:0]  m0_rresp,
    output logic               m0_rlast,
    output logic [USER_W-1:0]  m0_ruser,
    // master 1
    input  logic               m1_arvalid,
    output logic               m1_arready,
    input  logic [ID_W-1:0]    m1_arid,
    input  logic [ADDR_W-1:0]  m1_araddr,
    input  logic [LEN_W-1:0]   m1_arlen,
    input  logic [SIZE_W-1:0]  m1_arsize,
    input  logic [BURST_W-1:0] m1_arburst,
    input  logic [USER_W-1:0]  m1_aruser,
    output logic               m1_rvalid,
    input  logic               m1_rready,
    output logic [ID_W-1:0]    m1_rid,
    output logic [DATA_W-1:0]  m1_rdata,
    output logic [RESP_W-1:0]  m1_rresp,
    output logic               m1_rlast,
    output logic [USER_W-1:0]  m1_ruser,
    // slave
    output logic               slv_arvalid,
    input  logic               slv_arready,
    output logic [ID_W-1:0]    slv_arid,
    output logic [ADDR_W-1:0]  slv_araddr,
    output logic [LEN_W-1:0]   slv_arlen,
    output logic [SIZE_W-1:0]  slv_arsize,
    output logic [BURST_W-1:0] slv_arburst,
    output logic [USER_W-1:0]  slv_aruser,
    input  logic               slv_rvalid,
    output logic               slv_rready,
    input  logic [ID_W-1:0]    slv_rid,
    input  logic [DATA_W-1:0]  slv_rdata,
    input  logic [RESP_W-1:0]  slv_rresp,
    input  logic               slv_rlast,
    input  logic [USER_W-1:0]  slv_ruser,
    // status
    output logic [1:0]         grant,
    output logic               busy,
    output logic               len_err
);

    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {IDLE, AR_FWD, R_FWD} state_t;

    state_t           state;
    logic             prio;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             arb_sel;
    logic             sel;
    logic             r_hs;
    logic [CNT_W-1:0] len_ext;

    // Winner when idle: the lone requester, or prio on a tie
    assign arb_sel = (m0_arvalid && m1_arvalid) ? prio : m1_arvalid;
    assign sel     = grant[1];
    assign r_hs    = slv_rvalid && slv_rready;
    assign len_ext = {1'b0, len_q};
    assign busy    = (state != IDLE);

    // R payload goes to both masters; only the owner sees rvalid
    assign m0_rid   = slv_rid;
    assign m0_rdata = slv_rdata;
    assign m0_rresp = slv_rresp;
    assign m0_rlast = slv_rlast;
    assign m0_ruser = slv_ruser;
    assign m1_rid   = slv_rid;
    assign m1_rdata = slv_rdata;
    assign m1_rresp = slv_rresp;
    assign m1_rlast = slv_rlast;
    assign m1_ruser = slv_ruser;

    assign slv_arid    = sel ? m1_arid    : m0_arid;
    assign slv_araddr  = sel ? m1_araddr  : m0_araddr;
    assign slv_arlen   = sel ? m1_arlen   : m0_arlen;
    assign slv_arsize  = sel ? m1_arsize  : m0_arsize;
    assign slv_arburst = sel ? m1_arburst : m0_arburst;
    assign slv_aruser  = sel ? m1_aruser  : m0_aruser;

    // Handshake steering, gated by state so IDLE drives nothing
    always_comb begin
        slv_arvalid = 1'b0;
        slv_rready  = 1'b0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        case (state)
            AR_FWD: begin
                slv_arvalid = sel ? m1_arvalid : m0_arvalid;
                m0_arready  = grant[0] && slv_arready;
                m1_arready  = grant[1] && slv_arready;
            end
            R_FWD: begin
                slv_rready = sel ? m1_rready : m0_rready;
                m0_rvalid  = grant[0] && slv_rvalid;
                m1_rvalid  = grant[1] && slv_rvalid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= 2'b00;
            prio    <= 1'b0;
            cnt     <= '0;
            len_q   <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        grant <= arb_sel ? 2'b10 : 2'b01;
                        cnt   <= '0;
                        len_q <= arb_sel ? m1_arlen : m0_arlen;
                        state <= AR_FWD;
                    end
                end
                AR_FWD: begin
                    if (slv_arvalid && slv_arready) state <= R_FWD;
                end
                R_FWD: begin
                    if (r_hs) begin
                        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                        // Early rlast, or a missing rlast on the last expected beat
                        len_err <= slv_rlast ? (cnt != len_ext) : (cnt == len_ext);
                        if (slv_rlast) begin
                            state <= IDLE;
                            grant <= 2'b00;
                            prio  <= ~grant[1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Directed bench for easyaxi_rd_arb: reset, backpressure, round-robin,
// R steering and burst-length error pulses.
module tb_easyaxi_rd_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [3:0]  m0_arid, m0_rid;
    logic [31:0] m0_araddr, m0_rdata;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic [0:0]  m0_aruser, m0_ruser;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [3:0]  m1_arid, m1_rid;
    logic [31:0] m1_araddr, m1_rdata;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic [0:0]  m1_aruser, m1_ruser;
    logic        slv_arvalid, slv_arready, slv_rvalid, slv_rready, slv_rlast;
    logic [3:0]  slv_arid, slv_rid;
    logic [31:0] slv_araddr, slv_rdata;
    logic [7:0]  slv_arlen;
    logic [2:0]  slv_arsize;
    logic [1:0]  slv_arburst, slv_rresp;
    logic [0:0]  slv_aruser, slv_ruser;
    logic [1:0]  grant;
    logic        busy, len_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    easyaxi_rd_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_aruser(m0_aruser),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_ruser(m0_ruser),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_aruser(m1_aruser),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_ruser(m1_ruser),
        .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_arid(slv_arid),
        .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
        .slv_arburst(slv_arburst), .slv_aruser(slv_aruser),
        .slv_rvalid(slv_rvalid), .slv_rready(slv_rready), .slv_rid(slv_rid),
        .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast), .slv_ruser(slv_ruser),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for grant, do the AR handshake, then return nbeats slave beats with rlast on the final one
    task automatic burst(input string tag, input logic [1:0] exp_grant, input int nbeats,
                         input int exp_err, input bit keep);
        int t;
        int errs;
        int hs;
        t = 0;
        while (grant == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_grant"}, 64'(grant), 64'(exp_grant));
        slv_arready = 1'b1;
        #1;
        chk({tag, "_arready"}, 64'(exp_grant[0] ? m0_arready : m1_arready), 64'd1);
        @(negedge clk);
        slv_arready = 1'b0;
        if (!keep) begin
            if (exp_grant[0]) m0_arvalid = 1'b0;
            else              m1_arvalid = 1'b0;
        end
        errs = 0;
        hs   = 0;
        for (int i = 0; i < nbeats; i++) begin
            slv_rvalid = 1'b1;
            slv_rdata  = 32'hD000_0000 + 32'(i);
            slv_rlast  = (i == nbeats - 1);
            #1;
            if (slv_rvalid && slv_rready) hs++;
            chk({tag, "_rvalid_own"}, 64'(exp_grant[0] ? m0_rvalid : m1_rvalid), 64'd1);
            chk({tag, "_rvalid_other"}, 64'(exp_grant[0] ? m1_rvalid : m0_rvalid), 64'd0);
            @(negedge clk);
            if (len_err) errs++;
        end
        slv_rvalid = 1'b0;
        slv_rlast  = 1'b0;
        #1;
        chk({tag, "_hs"}, 64'(hs), 64'(nbeats));
        chk({tag, "_errs"}, 64'(errs), 64'(exp_err));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_turnaround"}, 64'(slv_arvalid), 64'd0);
        @(negedge clk);
        chk({tag, "_err_clear"}, 64'(len_err), 64'd0);
    endtask

    initial begin
        logic [1:0] rr_pat [4];
        logic [3:0] rdy_pat;
        int t;
        int hs;
        int beat;
        rst_n = 1'b0;
        m0_arvalid = 1'b1; m0_arid = 4'h3; m0_araddr = 32'h0000_1000; m0_arlen = 8'd3;
        m0_arsize = 3'd2; m0_arburst = 2'd1; m0_aruser = 1'b0; m0_rready = 1'b1;
        m1_arvalid = 1'b1; m1_arid = 4'hA; m1_araddr = 32'h0000_2000; m1_arlen = 8'd0;
        m1_arsize = 3'd2; m1_arburst = 2'd1; m1_aruser = 1'b1; m1_rready = 1'b1;
        slv_arready = 1'b0; slv_rvalid = 1'b0; slv_rid = 4'h5; slv_rdata = '0;
        slv_rresp = 2'd0; slv_rlast = 1'b0; slv_ruser = 1'b0;

        // Reset held with both requesting
        repeat (2) @(negedge clk);
        #1;
        chk("rst_slv_arvalid", 64'(slv_arvalid), 64'd0);
        chk("rst_m0_arready", 64'(m0_arready), 64'd0);
        chk("rst_m1_arready", 64'(m1_arready), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_grant", 64'(grant), 64'b01);
        chk("rel_slv_arvalid", 64'(slv_arvalid), 64'd1);

        // AR backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("arbp_slv_arvalid", 64'(slv_arvalid), 64'd1);
            chk("arbp_araddr", 64'(slv_araddr), 64'h1000);
            chk("arbp_arlen", 64'(slv_arlen), 64'd3);
            chk("arbp_m0_arready", 64'(m0_arready), 64'd0);
            chk("arbp_m1_arready", 64'(m1_arready), 64'd0);
            @(negedge clk);
        end
        chk("arbp_still_granted", 64'(grant), 64'b01);

        // Single 4-beat burst for m0
        burst("single", 2'b01, 4, 0, 1'b0);
        m0_arlen = 8'd0;

        // Round-robin with both requesting arlen=0; prio now points at m1
        rr_pat[0] = 2'b10; rr_pat[1] = 2'b01; rr_pat[2] = 2'b10; rr_pat[3] = 2'b01;
        m0_arvalid = 1'b1;
        burst("rr0", rr_pat[0], 1, 0, 1'b1);
        burst("rr1", rr_pat[1], 1, 0, 1'b1);
        burst("rr2", rr_pat[2], 1, 0, 1'b1);
        m1_arlen = 8'd1;
        burst("rr3", rr_pat[3], 1, 0, 1'b0);

        // R backpressure on m1, 2-beat burst
        t = 0;
        while (grant == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rbp_grant", 64'(grant), 64'b10);
        slv_arready = 1'b1;
        @(negedge clk);
        slv_arready = 1'b0;
        m1_arvalid  = 1'b0;
        rdy_pat = 4'b1001;
        hs = 0;
        beat = 0;
        for (int i = 0; i < 4; i++) begin
            m1_rready  = rdy_pat[3-i];
            slv_rvalid = 1'b1;
            slv_rdata  = 32'hB000_0000 + 32'(beat);
            slv_rlast  = (beat == 1);
            #1;
            chk("rbp_rready", 64'(slv_rready), 64'(rdy_pat[3-i]));
            chk("rbp_rdata", 64'(m1_rdata), 64'(32'hB000_0000 + 32'(beat)));
            if (slv_rvalid && slv_rready) begin
                hs++;
                beat++;
            end
            @(negedge clk);
            chk("rbp_len_err", 64'(len_err), 64'd0);
        end
        slv_rvalid = 1'b0;
        slv_rlast  = 1'b0;
        m1_rready  = 1'b1;
        #1;
        chk("rbp_hs", 64'(hs), 64'd2);
        chk("rbp_busy", 64'(busy), 64'd0);

        // Early rlast: arlen=2, rlast on beat 2
        m0_arlen = 8'd2;
        m0_arvalid = 1'b1;
        burst("len_short", 2'b01, 2, 1, 1'b0);
        // Late rlast: arlen=1, rlast on beat 3 (missing rlast on beat 2, then wrong count on 3)
        m0_arlen = 8'd1;
        m0_arvalid = 1'b1;
        burst("len_long", 2'b01, 3, 2, 1'b0);

        // Reset mid-burst aborts at once
        m1_arlen = 8'd3;
        m1_arvalid = 1'b1;
        t = 0;
        while (grant == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mrst_grant", 64'(grant), 64'b10);
        slv_arready = 1'b1;
        @(negedge clk);
        slv_arready = 1'b0;
        m1_arvalid  = 1'b0;
        slv_rvalid  = 1'b1;
        #1;
        chk("mrst_rvalid_pre", 64'(m1_rvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_rvalid", 64'(m1_rvalid), 64'd0);
        chk("mrst_rready", 64'(slv_rready), 64'd0);
        chk("mrst_grant0", 64'(grant), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_idle_arvalid", 64'(slv_arvalid), 64'd0);
        chk("mrst_idle_rvalid", 64'(m1_rvalid), 64'd0);
        chk("mrst_idle_busy", 64'(busy), 64'd0);
        slv_rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
